qdec_ctx_mem_arb: RTL and testbench

Single-port arbiter and hazard scoreboard for the CABAC context memory (1024 x 8, `{state[6:0], mps}` per entry). It sits between the context-memory users and the memory macro:

- the context initialiser (write-only bulk fill),
- two syntax-element read requesters (port 0 = SAO FSM, port 1 = CQT FSM),
- the arithmetic-decoder state write-back.

It issues at most one memory operation per cycle. It blocks read-after-write hazards on contexts whose updated state has not yet been written back, and forwards write-back data to a same-cycle read of the same address.

---
 rtl/qdec_ctx_mem_arb.sv | 192 +++++++++++++++++++
 tb/tb_qdec_ctx_mem_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_ctx_mem_arb.sv
// CABAC context memory arbiter with read-after-write hazard scoreboard.
// One memory operation per cycle: write-back > init > reads. Contexts that
// have been read but not yet written back are tracked in an ordered
// scoreboard (index 0 = oldest). A read of a context being written back in
// the same cycle is served from the write-back data instead of the macro.
module qdec_ctx_mem_arb #(
  parameter int PEND_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_vld,
  input  logic [9:0] init_addr,
  input  logic [7:0] init_wdata,
  output logic       init_rdy,
  input  logic [1:0] rd_req,
  input  logic [9:0] rd_addr0,
  input  logic [9:0] rd_addr1,
  output logic [1:0] rd_gnt,
  output logic [7:0] rd_data,
  output logic       rd_data_vld,
  output logic       rd_data_id,
  input  logic       wb_vld,
  input  logic [9:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       wb_rdy,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic [3:0] pend_cnt,
  output logic       err_wb_nomatch
);

  localparam int CW = 4;

  // Scoreboard: entries 0..sb_cnt_reg-1 are live, kept in insertion order.
  logic [9:0]          sb_addr_reg  [PEND_DEPTH];
  logic [9:0]          sb_addr_next [PEND_DEPTH];
  logic [9:0]          sb_compact   [PEND_DEPTH];
  logic [CW-1:0]       sb_cnt_reg;
  logic [CW-1:0]       sb_cnt_next;
  logic [CW-1:0]       cnt_after_clr;

  logic [PEND_DEPTH-1:0] sb_valid;
  logic [PEND_DEPTH-1:0] wb_match;
  logic [PEND_DEPTH-1:0] clr_sel;
  logic [PEND_DEPTH-1:0] shift_sel;
  logic [PEND_DEPTH-1:0] hit0;
  logic [PEND_DEPTH-1:0] hit1;
  logic                  match_seen;
  logic                  clr_hit;
  logic                  not_full;

  logic [1:0] elig;
  logic [1:0] gnt;
  logic       gnt_any;
  logic       gnt_id;
  logic [9:0] gnt_addr;
  logic       fwd;
  logic       last_reg;

  // Read pipeline: stage 1 tracks the macro read cycle, stage 2 is the output.
  logic       s1_vld_reg;
  logic       s1_id_reg;
  logic       s1_fwd_reg;
  logic [7:0] s1_fwd_data_reg;
  logic       rd_data_vld_reg;
  logic       rd_data_id_reg;
  logic [7:0] rd_data_reg;
  logic       err_reg;

  // Per-entry match terms; a read only collides with entries that survive this cycle's clear.
  for (genvar gi = 0; gi < PEND_DEPTH; gi++) begin : g_match
    assign sb_valid[gi]  = CW'(gi) < sb_cnt_reg;
    assign wb_match[gi]  = wb_vld && sb_valid[gi] && (sb_addr_reg[gi] == wb_addr);
    assign hit0[gi]      = sb_valid[gi] && !clr_sel[gi] && (sb_addr_reg[gi] == rd_addr0);
    assign hit1[gi]      = sb_valid[gi] && !clr_sel[gi] && (sb_addr_reg[gi] == rd_addr1);
    assign shift_sel[gi] = |clr_sel[gi:0];
  end

  // Pick the oldest (lowest index) entry matching the write-back address.
  always_comb begin
    match_seen = 1'b0;
    clr_sel    = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      clr_sel[i] = wb_match[i] & ~match_seen;
      match_seen = match_seen | wb_match[i];
    end
  end

  assign clr_hit       = |wb_match;
  assign cnt_after_clr = sb_cnt_reg - {{(CW-1){1'b0}}, clr_hit};
  assign not_full      = cnt_after_clr < CW'(PEND_DEPTH);

  // Eligibility; during a write-back only a read of that same address can go (forwarded).
  assign elig[0] = rd_req[0] && !init_vld && !(|hit0) && not_full && (!wb_vld || rd_addr0 == wb_addr);
  assign elig[1] = rd_req[1] && !init_vld && !(|hit1) && not_full && (!wb_vld || rd_addr1 == wb_addr);

  // Round-robin between the two ports when both are eligible.
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = last_reg ? 2'b01 : 2'b10;
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_id   = gnt[1];
  assign gnt_addr = gnt[1] ? rd_addr1 : rd_addr0;
  assign fwd      = gnt_any && wb_vld;
  assign rd_gnt   = gnt;

  // Remove the cleared entry by shifting younger entries down, then append the granted address.
  for (genvar gi = 0; gi < PEND_DEPTH; gi++) begin : g_next
    if (gi < PEND_DEPTH - 1) begin : g_shift
      assign sb_compact[gi] = shift_sel[gi] ? sb_addr_reg[gi+1] : sb_addr_reg[gi];
    end else begin : g_last
      assign sb_compact[gi] = sb_addr_reg[gi];
    end
    assign sb_addr_next[gi] = (gnt_any && cnt_after_clr == CW'(gi)) ? gnt_addr : sb_compact[gi];
  end

  assign sb_cnt_next = cnt_after_clr + {{(CW-1){1'b0}}, gnt_any};

  // Memory port mux: write-back, then init, then a non-forwarded read.
  always_comb begin
    init_rdy  = init_vld && !wb_vld && (sb_cnt_reg == '0);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wb_vld) begin
      mem_we    = 1'b1;
      mem_addr  = wb_addr;
      mem_wdata = wb_data;
    end else if (init_rdy) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr;
      mem_wdata = init_wdata;
    end else if (gnt_any) begin
      mem_re   = 1'b1;
      mem_addr = gnt_addr;
    end
  end

  // Scoreboard, arbitration pointer and error flag state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_cnt_reg <= '0;
      last_reg   <= 1'b1;
      err_reg    <= 1'b0;
      for (int i = 0; i < PEND_DEPTH; i++) sb_addr_reg[i] <= '0;
    end else begin
      sb_cnt_reg <= sb_cnt_next;
      err_reg    <= wb_vld && !clr_hit;
      if (gnt_any) last_reg <= gnt_id;
      for (int i = 0; i < PEND_DEPTH; i++) sb_addr_reg[i] <= sb_addr_next[i];
    end
  end

  // Two-stage read response pipeline; forwarded data rides alongside the macro read slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_reg      <= 1'b0;
      s1_id_reg       <= 1'b0;
      s1_fwd_reg      <= 1'b0;
      s1_fwd_data_reg <= '0;
      rd_data_vld_reg <= 1'b0;
      rd_data_id_reg  <= 1'b0;
      rd_data_reg     <= '0;
    end else begin
      s1_vld_reg      <= gnt_any;
      s1_id_reg       <= gnt_id;
      s1_fwd_reg      <= fwd;
      s1_fwd_data_reg <= wb_data;
      rd_data_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        rd_data_id_reg <= s1_id_reg;
        rd_data_reg    <= s1_fwd_reg ? s1_fwd_data_reg : mem_rdata;
      end
    end
  end

  assign wb_rdy         = 1'b1;
  assign rd_data        = rd_data_reg;
  assign rd_data_vld    = rd_data_vld_reg;
  assign rd_data_id     = rd_data_id_reg;
  assign pend_cnt       = sb_cnt_reg;
  assign err_wb_nomatch = err_reg;

endmodule

// File: tb/tb_qdec_ctx_mem_arb.sv
// Directed bench for qdec_ctx_mem_arb with a behavioural 1024x8 memory macro.
module tb_qdec_ctx_mem_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_vld;
  logic [9:0] init_addr;
  logic [7:0] init_wdata;
  logic       init_rdy;
  logic [1:0] rd_req;
  logic [9:0] rd_addr0;
  logic [9:0] rd_addr1;
  logic [1:0] rd_gnt;
  logic [7:0] rd_data;
  logic       rd_data_vld;
  logic       rd_data_id;
  logic       wb_vld;
  logic [9:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_rdy;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic [3:0] pend_cnt;
  logic       err_wb_nomatch;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_model [1024];

  always #5 clk = ~clk;

  qdec_ctx_mem_arb #(.PEND_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_vld(init_vld), .init_addr(init_addr), .init_wdata(init_wdata), .init_rdy(init_rdy),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_data_id(rd_data_id),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data), .wb_rdy(wb_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .pend_cnt(pend_cnt), .err_wb_nomatch(err_wb_nomatch)
  );

  // Memory macro: one-cycle write, registered read.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [9:0] a0, a1;
    logic       wbv;
    logic [9:0] wba;
    logic [7:0] wbd;
    logic [1:0] gnt;
    logic       we, re;
    logic [9:0] maddr;
    logic [3:0] pend;
    logic       err, vld, id;
    logic [7:0] data;
  } vec_t;

  vec_t vq[$];

  // Vector: rst_n, req, a0, a1, wb_vld, wb_addr, wb_data | gnt, we, re, mem_addr, pend_cnt, err, vld, id, data
  function automatic vec_t mk(int rst, int req, int a0, int a1, int wbv, int wba, int wbd,
                              int gnt, int we, int re, int maddr, int pend, int err,
                              int vld, int id, int data);
    vec_t v;
    v.rst = 1'(rst);   v.req = 2'(req);  v.a0 = 10'(a0);    v.a1 = 10'(a1);
    v.wbv = 1'(wbv);   v.wba = 10'(wba); v.wbd = 8'(wbd);   v.gnt = 2'(gnt);
    v.we = 1'(we);     v.re = 1'(re);    v.maddr = 10'(maddr); v.pend = 4'(pend);
    v.err = 1'(err);   v.vld = 1'(vld);  v.id = 1'(id);     v.data = 8'(data);
    return v;
  endfunction

  task automatic build_vectors();
    // Round-robin with write-back 3 cycles after every grant
    vq.push_back(mk(1,3,10,20, 0,0,0,      1,0,1,10, 0,0, 0,0,0));
    vq.push_back(mk(1,3,10,20, 0,0,0,      2,0,1,20, 1,0, 0,0,0));
    vq.push_back(mk(1,3,10,20, 0,0,0,      0,0,0,0,  2,0, 1,0,10));
    vq.push_back(mk(1,3,10,20, 1,10,'hA1,  1,1,0,10, 2,0, 1,1,20));
    vq.push_back(mk(1,3,10,20, 1,20,'hB2,  2,1,0,20, 2,0, 0,0,0));
    vq.push_back(mk(1,3,10,20, 0,0,0,      0,0,0,0,  2,0, 1,0,'hA1));
    vq.push_back(mk(1,3,10,20, 1,10,'hC3,  1,1,0,10, 2,0, 1,1,'hB2));
    vq.push_back(mk(1,3,10,20, 1,20,'hD4,  2,1,0,20, 2,0, 0,0,0));
    vq.push_back(mk(1,0,10,20, 0,0,0,      0,0,0,0,  2,0, 1,0,'hC3));
    vq.push_back(mk(1,0,10,20, 1,10,'hE5,  0,1,0,10, 2,0, 1,1,'hD4));
    vq.push_back(mk(1,0,10,20, 1,20,'hF6,  0,1,0,20, 1,0, 0,0,0));
    // RAW block on port 1, address 5, released by forwarding
    vq.push_back(mk(1,2,0,5, 0,0,0,        2,0,1,5,  0,0, 0,0,0));
    vq.push_back(mk(1,2,0,5, 0,0,0,        0,0,0,0,  1,0, 0,0,0));
    vq.push_back(mk(1,2,0,5, 0,0,0,        0,0,0,0,  1,0, 1,1,5));
    vq.push_back(mk(1,2,0,5, 1,5,'h5A,     2,1,0,5,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,5, 0,0,0,        0,0,0,0,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,5, 0,0,0,        0,0,0,0,  1,0, 1,1,'h5A));
    vq.push_back(mk(1,0,0,5, 1,5,'h5A,     0,1,0,5,  1,0, 0,0,0));
    // Write-back to 7 blocks port 0 read of 9 for one cycle
    vq.push_back(mk(1,1,9,0, 1,7,'h77,     0,1,0,7,  0,0, 0,0,0));
    vq.push_back(mk(1,1,9,0, 0,0,0,        1,0,1,9,  0,1, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  1,0, 1,0,9));
    vq.push_back(mk(1,0,0,0, 1,9,'h99,     0,1,0,9,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,0, 0,0,0));
    // Full scoreboard: reads of 1..4, then stalls until clears free space
    vq.push_back(mk(1,1,1,0, 0,0,0,        1,0,1,1,  0,0, 0,0,0));
    vq.push_back(mk(1,1,2,0, 0,0,0,        1,0,1,2,  1,0, 0,0,0));
    vq.push_back(mk(1,1,3,0, 0,0,0,        1,0,1,3,  2,0, 1,0,1));
    vq.push_back(mk(1,1,4,0, 0,0,0,        1,0,1,4,  3,0, 1,0,2));
    vq.push_back(mk(1,3,1,6, 0,0,0,        0,0,0,0,  4,0, 1,0,3));
    vq.push_back(mk(1,3,1,6, 0,0,0,        0,0,0,0,  4,0, 1,0,4));
    vq.push_back(mk(1,3,1,6, 1,1,'h11,     1,1,0,1,  4,0, 0,0,0));
    vq.push_back(mk(1,2,0,6, 0,0,0,        0,0,0,0,  4,0, 0,0,0));
    vq.push_back(mk(1,2,0,6, 1,2,'h22,     0,1,0,2,  4,0, 1,0,'h11));
    vq.push_back(mk(1,2,0,6, 0,0,0,        2,0,1,6,  3,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  4,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 1,3,'h33,     0,1,0,3,  4,0, 1,1,6));
    vq.push_back(mk(1,0,0,0, 1,4,'h44,     0,1,0,4,  3,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 1,1,'h11,     0,1,0,1,  2,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 1,6,'h66,     0,1,0,6,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,0, 0,0,0));
    // Unmatched write-back raises a one-cycle error pulse
    vq.push_back(mk(1,0,0,0, 1,300,0,      0,1,0,300,0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,1, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,0, 0,0,0));
    // Reset one cycle after a grant drops the response; pointer back to 1
    vq.push_back(mk(1,1,12,0, 0,0,0,       1,0,1,12, 0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,0,  1,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  0,0, 0,0,0));
    vq.push_back(mk(1,3,12,13, 0,0,0,      1,0,1,12, 0,0, 0,0,0));
    vq.push_back(mk(1,3,14,13, 0,0,0,      2,0,1,13, 1,0, 0,0,0));
    vq.push_back(mk(1,3,14,15, 0,0,0,      1,0,1,14, 2,0, 1,0,12));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  3,0, 1,1,13));
    vq.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,0,  3,0, 1,0,14));
  endtask

  initial begin
    int n_rdy, n_we, n_pend_bad, n_gnt;
    rst_n = 1'b0; init_vld = 1'b0; init_addr = '0; init_wdata = '0;
    rd_req = '0; rd_addr0 = '0; rd_addr1 = '0;
    wb_vld = 1'b0; wb_addr = '0; wb_data = '0;
    build_vectors();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_vld",   32'(rd_data_vld), 32'd0);
    check_val("rst_data",  32'(rd_data), 32'd0);
    check_val("rst_id",    32'(rd_data_id), 32'd0);
    check_val("rst_pend",  32'(pend_cnt), 32'd0);
    check_val("rst_err",   32'(err_wb_nomatch), 32'd0);
    check_val("rst_gnt",   32'(rd_gnt), 32'd0);
    check_val("rst_we",    32'(mem_we), 32'd0);
    check_val("rst_re",    32'(mem_re), 32'd0);
    check_val("rst_maddr", 32'(mem_addr), 32'd0);
    check_val("rst_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_irdy",  32'(init_rdy), 32'd0);
    check_val("rst_wbrdy", 32'(wb_rdy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Init fill of the whole memory, data = addr[7:0]
    n_rdy = 0; n_we = 0; n_pend_bad = 0; n_gnt = 0;
    for (int a = 0; a < 1024; a++) begin
      init_vld   = 1'b1;
      init_addr  = 10'(a);
      init_wdata = 8'(a);
      @(negedge clk);
      if (init_rdy) n_rdy++;
      if (mem_we && !mem_re && mem_addr == 10'(a) && mem_wdata == 8'(a)) n_we++;
      if (pend_cnt != 4'd0) n_pend_bad++;
      if (rd_gnt != 2'b00) n_gnt++;
      @(posedge clk);
      #1;
    end
    init_vld = 1'b0;
    check_val("init_rdy_cycles", 32'(n_rdy), 32'd1024);
    check_val("init_we_cycles",  32'(n_we), 32'd1024);
    check_val("init_pend_nonzero", 32'(n_pend_bad), 32'd0);
    check_val("init_gnt_cycles", 32'(n_gnt), 32'd0);
    $display("init fill: rdy=%0d we=%0d", n_rdy, n_we);

    // Directed per-cycle vectors
    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      string rn;
      v  = vq[i];
      rn = $sformatf("v%0d", i);
      rst_n = v.rst; rd_req = v.req; rd_addr0 = v.a0; rd_addr1 = v.a1;
      wb_vld = v.wbv; wb_addr = v.wba; wb_data = v.wbd;
      @(negedge clk);
      $display("%s: req=%b wb=%0b/%0d gnt=%b we=%0b re=%0b pend=%0d vld=%0b id=%0b data=%0h",
               rn, rd_req, wb_vld, wb_addr, rd_gnt, mem_we, mem_re, pend_cnt, rd_data_vld, rd_data_id, rd_data);
      check_val({rn, "_gnt"},  32'(rd_gnt), 32'(v.gnt));
      check_val({rn, "_we"},   32'(mem_we), 32'(v.we));
      check_val({rn, "_re"},   32'(mem_re), 32'(v.re));
      if (v.we || v.re) check_val({rn, "_maddr"}, 32'(mem_addr), 32'(v.maddr));
      if (v.we && v.wbv) check_val({rn, "_wdata"}, 32'(mem_wdata), 32'(v.wbd));
      check_val({rn, "_pend"}, 32'(pend_cnt), 32'(v.pend));
      check_val({rn, "_err"},  32'(err_wb_nomatch), 32'(v.err));
      check_val({rn, "_vld"},  32'(rd_data_vld), 32'(v.vld));
      if (v.vld) begin
        check_val({rn, "_id"},   32'(rd_data_id), 32'(v.id));
        check_val({rn, "_data"}, 32'(rd_data), 32'(v.data));
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
